// File: rtl/sdram_responder.sv
// sdram_responder: chip-side SDR SDRAM device model for loopback builds and controller benches.
// It decodes pin commands, tracks banks and the mode register, stores data on chip and returns CAS-delayed bursts.
module sdram_responder #(
    parameter int BANK_ADDRESS_WIDTH   = 2,
    parameter int ROW_ADDRESS_WIDTH    = 12,
    parameter int COLUMN_ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH           = 16,
    parameter int DQM_WIDTH            = 2,
    parameter int STORED_ROW_BITS      = 2,
    localparam int CHIP_ADDRESS_WIDTH  =
        (ROW_ADDRESS_WIDTH >= COLUMN_ADDRESS_WIDTH)
            ? ((ROW_ADDRESS_WIDTH >= 11) ? ROW_ADDRESS_WIDTH : 11)
            : ((COLUMN_ADDRESS_WIDTH >= 11) ? COLUMN_ADDRESS_WIDTH : 11)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clock_enable,
    input  logic [BANK_ADDRESS_WIDTH-1:0] bank_activate,
    input  logic [CHIP_ADDRESS_WIDTH-1:0] address,
    input  logic                          chip_select,
    input  logic                          row_address_strobe,
    input  logic                          column_address_strobe,
    input  logic                          write_enable,
    input  logic [DQM_WIDTH-1:0]          dqm,
    inout  wire  [DATA_WIDTH-1:0]         dq,
    output logic                          init_done,
    output logic                          protocol_error,
    output logic [9:0]                    mode_register
);

    localparam int NUM_BANKS           = 1 << BANK_ADDRESS_WIDTH;
    localparam int LANE_WIDTH          = DATA_WIDTH / DQM_WIDTH;
    localparam int ARRAY_ADDRESS_WIDTH = BANK_ADDRESS_WIDTH + STORED_ROW_BITS + COLUMN_ADDRESS_WIDTH;
    localparam int ARRAY_DEPTH         = 1 << ARRAY_ADDRESS_WIDTH;
    localparam int CL_MAX              = 3;
    localparam logic [9:0] MODE_RESET  = 10'h020;

    typedef enum logic [2:0] {
        CMD_MRS        = 3'b000,
        CMD_REFRESH    = 3'b001,
        CMD_PRECHARGE  = 3'b010,
        CMD_ACTIVE     = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_READ       = 3'b101,
        CMD_BURST_STOP = 3'b110,
        CMD_NOP        = 3'b111
    } command_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_BURST,
        WRITE_BURST
    } burst_state_t;

    function automatic logic [COLUMN_ADDRESS_WIDTH-1:0] burst_mask(input logic [2:0] code);
        case (code)
            3'd1:    return COLUMN_ADDRESS_WIDTH'(1);
            3'd2:    return COLUMN_ADDRESS_WIDTH'(3);
            3'd3:    return COLUMN_ADDRESS_WIDTH'(7);
            3'd7:    return '1;
            default: return '0;
        endcase
    endfunction

    function automatic logic burst_code_legal(input logic [2:0] code);
        return code inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    endfunction

    function automatic logic latency_code_legal(input logic [2:0] code);
        return code inside {3'd2, 3'd3};
    endfunction

    command_t                          command;
    burst_state_t                      burst_state;
    logic [NUM_BANKS-1:0]              bank_open;
    logic [STORED_ROW_BITS-1:0]        bank_row [NUM_BANKS];
    logic                              mrs_seen;
    logic [1:0]                        refresh_count;

    logic [BANK_ADDRESS_WIDTH-1:0]     burst_bank;
    logic [STORED_ROW_BITS-1:0]        burst_row;
    logic [COLUMN_ADDRESS_WIDTH-1:0]   burst_start;
    logic [COLUMN_ADDRESS_WIDTH-1:0]   burst_wrap;
    logic [COLUMN_ADDRESS_WIDTH-1:0]   burst_last_index;
    logic [COLUMN_ADDRESS_WIDTH-1:0]   burst_count;
    logic                              burst_auto_precharge;

    logic [DATA_WIDTH-1:0]             mem [ARRAY_DEPTH];
    logic [DQM_WIDTH-1:0]              pipe_valid [CL_MAX];
    logic [DATA_WIDTH-1:0]             pipe_data [CL_MAX];
    logic [DQM_WIDTH-1:0]              out_valid;
    logic [DATA_WIDTH-1:0]             out_data;

    logic                              rw_command;
    logic                              activate_ok;
    logic                              rw_ok;
    logic                              command_error;
    logic [COLUMN_ADDRESS_WIDTH-1:0]   wrap_mask;
    logic [COLUMN_ADDRESS_WIDTH-1:0]   command_last_index;
    logic                              cas_latency_three;
    logic                              single_write;

    logic                              beat_valid;
    logic                              beat_read;
    logic                              beat_last;
    logic                              beat_auto_precharge;
    logic [BANK_ADDRESS_WIDTH-1:0]     beat_bank;
    logic [STORED_ROW_BITS-1:0]        beat_row;
    logic [COLUMN_ADDRESS_WIDTH-1:0]   beat_col;
    logic [ARRAY_ADDRESS_WIDTH-1:0]    beat_addr;

    // Row bits above STORED_ROW_BITS alias onto the stored rows and are deliberately dropped.
    logic unused_address_bits;
    assign unused_address_bits = ^address;

    assign command = (clock_enable && !chip_select)
                   ? command_t'({row_address_strobe, column_address_strobe, write_enable})
                   : CMD_NOP;

    assign wrap_mask         = burst_mask(mode_register[2:0]);
    assign cas_latency_three = (mode_register[6:4] == 3'd3);
    assign single_write      = mode_register[9];

    assign rw_command  = (command == CMD_READ) || (command == CMD_WRITE);
    assign activate_ok = (command == CMD_ACTIVE) && init_done && !bank_open[bank_activate];
    assign rw_ok       = rw_command && init_done && bank_open[bank_activate];

    assign command_last_index = (command == CMD_WRITE && single_write) ? '0 : wrap_mask;

    assign command_error =
        (((command == CMD_ACTIVE) || rw_command) && !init_done) ||
        ((command == CMD_ACTIVE) && init_done && bank_open[bank_activate]) ||
        (rw_command && init_done && !bank_open[bank_activate]) ||
        (((command == CMD_REFRESH) || (command == CMD_MRS)) && (|bank_open)) ||
        ((command == CMD_MRS) && (!burst_code_legal(address[2:0]) ||
                                  !latency_code_legal(address[6:4])));

    // One beat per edge: a fresh READ/WRITE supplies beat 0, otherwise a running burst supplies beat k.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        beat_valid          = 1'b0;
        beat_read           = 1'b0;
        beat_last           = 1'b0;
        beat_auto_precharge = 1'b0;
        beat_bank           = burst_bank;
        beat_row            = burst_row;
        beat_col            = (burst_start & ~burst_wrap) | ((burst_start + burst_count) & burst_wrap);
        if (rw_ok) begin
            beat_valid          = 1'b1;
            beat_read           = (command == CMD_READ);
            beat_last           = (command_last_index == '0);
            beat_auto_precharge = address[10];
            beat_bank           = bank_activate;
            beat_row            = bank_row[bank_activate];
            beat_col            = address[COLUMN_ADDRESS_WIDTH-1:0];
        end else if (burst_state != IDLE && command != CMD_BURST_STOP) begin
            beat_valid          = 1'b1;
            beat_read           = (burst_state == READ_BURST);
            beat_last           = (burst_count == burst_last_index);
            beat_auto_precharge = burst_auto_precharge;
        end
    end

    assign beat_addr = {beat_bank, beat_row, beat_col};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_state          <= IDLE;
            bank_open            <= '0;
            mode_register        <= MODE_RESET;
            init_done            <= 1'b0;
            protocol_error       <= 1'b0;
            mrs_seen             <= 1'b0;
            refresh_count        <= '0;
            burst_bank           <= '0;
            burst_row            <= '0;
            burst_start          <= '0;
            burst_wrap           <= '0;
            burst_last_index     <= '0;
            burst_count          <= '0;
            burst_auto_precharge <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_row[b] <= '0;
            end
            for (int s = 0; s < CL_MAX; s++) begin
                pipe_valid[s] <= '0;
            end
        end else if (clock_enable) begin
            if (command_error) begin
                protocol_error <= 1'b1;
            end

            pipe_valid[0] <= (beat_valid && beat_read) ? ~dqm : '0;
            for (int s = 1; s < CL_MAX; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
            end

            if (beat_valid && beat_last && beat_auto_precharge) begin
                bank_open[beat_bank] <= 1'b0;
            end

            if (rw_ok) begin
                burst_bank           <= bank_activate;
                burst_row            <= bank_row[bank_activate];
                burst_start          <= address[COLUMN_ADDRESS_WIDTH-1:0];
                burst_wrap           <= wrap_mask;
                burst_last_index     <= command_last_index;
                burst_count          <= COLUMN_ADDRESS_WIDTH'(1);
                burst_auto_precharge <= address[10];
                if (beat_last) begin
                    burst_state <= IDLE;
                end else begin
                    burst_state <= (command == CMD_READ) ? READ_BURST : WRITE_BURST;
                end
            end else if (burst_state != IDLE) begin
                if (command == CMD_BURST_STOP || beat_last) begin
                    burst_state <= IDLE;
                end else begin
                    burst_count <= burst_count + COLUMN_ADDRESS_WIDTH'(1);
                end
            end

            case (command)
                CMD_ACTIVE: begin
                    if (activate_ok) begin
                        bank_open[bank_activate] <= 1'b1;
                        bank_row[bank_activate]  <= address[STORED_ROW_BITS-1:0];
                    end
                end
                CMD_PRECHARGE: begin
                    if (address[10]) begin
                        bank_open <= '0;
                    end else begin
                        bank_open[bank_activate] <= 1'b0;
                    end
                end
                CMD_REFRESH: begin
                    if (mrs_seen && !init_done) begin
                        refresh_count <= refresh_count + 2'd1;
                        if (refresh_count == 2'd1) begin
                            init_done <= 1'b1;
                        end
                    end
                end
                CMD_MRS: begin
                    mode_register <= address[9:0];
                    mrs_seen      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the storage array and read data path carry no reset; only the valid flags gate what reaches dq.
    always_ff @(posedge clk) begin
        if (clock_enable) begin
            if (beat_valid && !beat_read) begin
                for (int lane = 0; lane < DQM_WIDTH; lane++) begin
                    if (!dqm[lane]) begin
                        mem[beat_addr][lane*LANE_WIDTH +: LANE_WIDTH] <= dq[lane*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
            pipe_data[0] <= mem[beat_addr];
            for (int s = 1; s < CL_MAX; s++) begin
                pipe_data[s] <= pipe_data[s-1];
            end
        end
    end

    assign out_valid = cas_latency_three ? pipe_valid[2] : pipe_valid[1];
    assign out_data  = cas_latency_three ? pipe_data[2]  : pipe_data[1];

    for (genvar lane = 0; lane < DQM_WIDTH; lane++) begin : g_dq_lane
        assign dq[lane*LANE_WIDTH +: LANE_WIDTH] =
            out_valid[lane] ? out_data[lane*LANE_WIDTH +: LANE_WIDTH] : {LANE_WIDTH{1'bz}};
    end

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: drives pin-level SDRAM commands into sdram_responder and scores dq per capture edge.
// The dq net is pulled up, so an undriven bus reads as all ones.
`timescale 1ns/1ps
module tb_sdram_responder;

    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [15:0] HIZ  = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        clock_enable = 1'b1;
    logic [1:0]  bank_activate = '0;
    logic [11:0] address = '0;
    logic        chip_select = 1'b1;
    logic        row_address_strobe = 1'b1;
    logic        column_address_strobe = 1'b1;
    logic        write_enable = 1'b1;
    logic [1:0]  dqm = '0;
    tri1  [15:0] dq;
    logic [15:0] dq_drv = '0;
    logic        dq_oe = 1'b0;
    logic        init_done;
    logic        protocol_error;
    logic [9:0]  mode_register;

    assign dq = dq_oe ? dq_drv : 16'bz;

    sdram_responder dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .clock_enable          (clock_enable),
        .bank_activate         (bank_activate),
        .address               (address),
        .chip_select           (chip_select),
        .row_address_strobe    (row_address_strobe),
        .column_address_strobe (column_address_strobe),
        .write_enable          (write_enable),
        .dqm                   (dqm),
        .dq                    (dq),
        .init_done             (init_done),
        .protocol_error        (protocol_error),
        .mode_register         (mode_register)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: expected dq value for a given capture edge number.
    typedef struct {
        int unsigned edge_no;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t sb_head;

    task automatic expect_dq(input int unsigned edge_no, input logic [15:0] data);
        sb.push_back('{edge_no, data});
    endtask

    // Sample mid-cycle: what is on dq now is what the next rising edge (cyc+1) would capture.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_no == cyc + 1) begin
            sb_head = sb.pop_front();
            check($sformatf("dq@edge%0d", sb_head.edge_no), dq, sb_head.data);
        end
    end

    int unsigned t_cmd;

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [11:0] a);
        chip_select = 1'b0;
        {row_address_strobe, column_address_strobe, write_enable} = c;
        bank_activate = ba;
        address = a;
        @(posedge clk);
        #1;
        t_cmd = cyc;
        chip_select = 1'b1;
        {row_address_strobe, column_address_strobe, write_enable} = 3'b111;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        summary();
        $finish;
    end

    logic [15:0] burst_words [4];

    initial begin
        burst_words[0] = 16'h1111;
        burst_words[1] = 16'h2222;
        burst_words[2] = 16'h3333;
        burst_words[3] = 16'h4444;

        // Reset state
        #2 reset_n = 1'b0;
        #2;
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_protocol_error", 32'(protocol_error), 32'h0);
        check("rst_mode_register", 32'(mode_register), 32'h020);
        check("rst_dq_hiz", 32'(dq), 32'(HIZ));
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // 1: initialisation sequence
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_MRS, 2'd0, 12'h220);
        check("t1_mode_register", 32'(mode_register), 32'h220);
        issue(C_REF, 2'd0, 12'h000);
        check("t1_init_after_one_ref", 32'(init_done), 32'h0);
        issue(C_REF, 2'd0, 12'h000);
        check("t1_init_after_two_ref", 32'(init_done), 32'h1);
        check("t1_protocol_error", 32'(protocol_error), 32'h0);

        // 2: single write with auto precharge, single read with auto precharge
        issue(C_ACT, 2'd1, 12'h003);
        dq_oe = 1'b1;
        dq_drv = 16'hBEEF;
        issue(C_WR, 2'd1, 12'h410);
        dq_oe = 1'b0;
        issue(C_ACT, 2'd1, 12'h003);
        check("t2_reopen_after_write_ap", 32'(protocol_error), 32'h0);
        issue(C_RD, 2'd1, 12'h410);
        expect_dq(t_cmd + 1, HIZ);
        expect_dq(t_cmd + 2, 16'hBEEF);
        expect_dq(t_cmd + 3, HIZ);
        idle(4);
        issue(C_ACT, 2'd1, 12'h003);
        check("t2_reopen_after_read_ap", 32'(protocol_error), 32'h0);

        // 3: BL4 CL3 burst write at col 6, wrap order 6,7,4,5
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_MRS, 2'd0, 12'h032);
        check("t3_mode_register", 32'(mode_register), 32'h032);
        issue(C_ACT, 2'd1, 12'h003);
        dq_oe = 1'b1;
        dq_drv = burst_words[0];
        issue(C_WR, 2'd1, 12'h006);
        for (int k = 1; k < 4; k++) begin
            dq_drv = burst_words[k];
            idle(1);
        end
        dq_oe = 1'b0;
        issue(C_RD, 2'd1, 12'h006);
        expect_dq(t_cmd + 2, HIZ);
        for (int k = 0; k < 4; k++) begin
            expect_dq(t_cmd + 3 + k, burst_words[k]);
        end
        expect_dq(t_cmd + 7, HIZ);
        idle(8);
        // Reading from col 4 exposes the stored column order
        issue(C_RD, 2'd1, 12'h004);
        expect_dq(t_cmd + 3, 16'h3333);
        expect_dq(t_cmd + 4, 16'h4444);
        expect_dq(t_cmd + 5, 16'h1111);
        expect_dq(t_cmd + 6, 16'h2222);
        idle(8);

        // 4: BL8 read cut short by BURST STOP at T+2
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_MRS, 2'd0, 12'h033);
        issue(C_ACT, 2'd1, 12'h003);
        issue(C_RD, 2'd1, 12'h004);
        expect_dq(t_cmd + 2, HIZ);
        expect_dq(t_cmd + 3, 16'h3333);
        expect_dq(t_cmd + 4, 16'h4444);
        expect_dq(t_cmd + 5, HIZ);
        expect_dq(t_cmd + 6, HIZ);
        idle(1);
        issue(C_BST, 2'd0, 12'h000);
        idle(8);

        // 5: byte-masked write, then masked read
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_MRS, 2'd0, 12'h020);
        issue(C_ACT, 2'd2, 12'h001);
        dq_oe = 1'b1;
        dq_drv = 16'h5555;
        dqm = 2'b00;
        issue(C_WR, 2'd2, 12'h020);
        dq_drv = 16'hAAAA;
        dqm = 2'b10;
        issue(C_WR, 2'd2, 12'h020);
        dq_oe = 1'b0;
        dqm = 2'b00;
        issue(C_RD, 2'd2, 12'h020);
        expect_dq(t_cmd + 2, 16'h55AA);
        dqm = 2'b11;
        issue(C_RD, 2'd2, 12'h020);
        dqm = 2'b00;
        expect_dq(t_cmd + 2, HIZ);
        idle(4);
        check("t5_no_error_yet", 32'(protocol_error), 32'h0);

        // 6: protocol violations, then reset during an active read
        issue(C_RD, 2'd3, 12'h000);
        expect_dq(t_cmd + 1, HIZ);
        expect_dq(t_cmd + 2, HIZ);
        expect_dq(t_cmd + 3, HIZ);
        check("t6_err_read_closed", 32'(protocol_error), 32'h1);
        issue(C_ACT, 2'd2, 12'h001);
        idle(4);
        check("t6_err_sticky", 32'(protocol_error), 32'h1);
        issue(C_RD, 2'd2, 12'h020);
        idle(1);
        check("t6_dq_before_reset", 32'(dq), 32'h55AA);
        #2 reset_n = 1'b0;
        #1;
        check("t6_dq_hiz_on_reset", 32'(dq), 32'(HIZ));
        check("t6_init_done_reset", 32'(init_done), 32'h0);
        check("t6_protocol_error_reset", 32'(protocol_error), 32'h0);
        check("t6_mode_register_reset", 32'(mode_register), 32'h020);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            idle(1);
        end
        if (sb.size() != 0) begin
            check("scoreboard_drain", 32'(sb.size()), 32'h0);
        end

        summary();
        $finish;
    end

endmodule
